ptvm_multi_vend: RTL and testbench



---
 rtl/ptvm_pkg.sv | 21 ++
 rtl/ptvm_coin_decode.sv | 24 ++
 rtl/ptvm_multi_vend.sv | 161 ++++++++++++++++
 tb/tb_ptvm_multi_vend.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ptvm_pkg.sv
// Shared types and helpers for the multi-ticket vending controller.
package ptvm_pkg;
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VEND, S_CHANGE} state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_A    = 2'b01;
  localparam logic [1:0] COIN_B    = 2'b10;
  localparam logic [1:0] COIN_C    = 2'b11;

  localparam int MAX_TICKET = 8;
  localparam int MAX_CW     = 32;

  // Prices arrive zero-extended to the maximum table size; caller truncates to its width.
  function automatic logic [MAX_CW-1:0] price_of(
    input logic [MAX_TICKET*MAX_CW-1:0] prices,
    input int                           cw,
    input logic [2:0]                   id
  );
    return prices[int'(id)*cw +: MAX_CW];
  endfunction
endpackage

// File: rtl/ptvm_coin_decode.sv
// Combinational coin-code to value mapping.
module ptvm_coin_decode
  import ptvm_pkg::*;
#(
  parameter int CREDIT_W = 8,
  parameter int COIN1    = 1,
  parameter int COIN2    = 2,
  parameter int COIN3    = 5
) (
  input  logic [1:0]          coin_code_i,
  output logic [CREDIT_W-1:0] value_o,
  output logic                valid_o
);
  always_comb begin
    value_o = '0;
    valid_o = 1'b1;
    case (coin_code_i)
      COIN_A:  value_o = CREDIT_W'(COIN1);
      COIN_B:  value_o = CREDIT_W'(COIN2);
      COIN_C:  value_o = CREDIT_W'(COIN3);
      default: valid_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/ptvm_multi_vend.sv
// Multi-ticket vending FSM: selection, coin collection, ticket issue, change return.
module ptvm_multi_vend
  import ptvm_pkg::*;
#(
  parameter int                          N_TICKET = 4,
  parameter int                          CREDIT_W = 8,
  parameter logic [N_TICKET*CREDIT_W-1:0] PRICES  = {8'd12, 8'd8, 8'd5, 8'd3},
  parameter int                          COIN1    = 1,
  parameter int                          COIN2    = 2,
  parameter int                          COIN3    = 5,
  parameter int                          CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sel_valid,
  input  logic [2:0]          sel_id,
  input  logic                coin_valid,
  input  logic [1:0]          coin_code,
  input  logic                cancel,
  output logic                ticket_valid,
  output logic [2:0]          ticket_id,
  input  logic                ticket_ready,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  input  logic                change_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                coin_reject,
  output logic                sel_err,
  output logic [CNT_W-1:0]    sold_cnt
);
  localparam logic [MAX_TICKET*MAX_CW-1:0] PRICES_X = (MAX_TICKET*MAX_CW)'(PRICES);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d, price_q, price_d, camt_q, camt_d;
  logic [2:0]          tid_q, tid_d;
  logic                tv_q, tv_d, cv_q, cv_d, rej_q, rej_d, serr_q, serr_d, busy_q, busy_d;
  logic [CNT_W-1:0]    sold_q, sold_d;

  logic [CREDIT_W-1:0] coin_val, sel_price, diff;
  logic                coin_ok_code;
  logic [CREDIT_W:0]   sum;

  ptvm_coin_decode #(
    .CREDIT_W(CREDIT_W), .COIN1(COIN1), .COIN2(COIN2), .COIN3(COIN3)
  ) u_dec (
    .coin_code_i(coin_code),
    .value_o    (coin_val),
    .valid_o    (coin_ok_code)
  );

  assign sel_price = CREDIT_W'(price_of(PRICES_X, CREDIT_W, sel_id));
  // Extra carry bit detects a coin that would overflow the credit register.
  assign sum  = {1'b0, credit_q} + {1'b0, coin_val};
  assign diff = credit_q - price_q;

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    price_d  = price_q;
    tid_d    = tid_q;
    tv_d     = tv_q;
    cv_d     = cv_q;
    camt_d   = camt_q;
    rej_d    = coin_valid;
    serr_d   = 1'b0;
    sold_d   = sold_q;
    case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          if (int'(sel_id) < N_TICKET) begin
            tid_d   = sel_id;
            price_d = sel_price;
            state_d = S_COLLECT;
          end else begin
            serr_d = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        if (cancel) begin
          if (credit_q != '0) begin
            cv_d    = 1'b1;
            camt_d  = credit_q;
            state_d = S_CHANGE;
          end else begin
            state_d = S_IDLE;
          end
        end else if (coin_valid && coin_ok_code && !sum[CREDIT_W]) begin
          rej_d    = 1'b0;
          credit_d = sum[CREDIT_W-1:0];
          if (sum[CREDIT_W-1:0] >= price_q) begin
            tv_d    = 1'b1;
            state_d = S_VEND;
          end
        end
      end
      S_VEND: begin
        if (ticket_ready) begin
          tv_d   = 1'b0;
          sold_d = sold_q + 1'b1;
          if (diff != '0) begin
            cv_d    = 1'b1;
            camt_d  = diff;
            state_d = S_CHANGE;
          end else begin
            credit_d = '0;
            state_d  = S_IDLE;
          end
        end
      end
      S_CHANGE: begin
        if (change_ready) begin
          cv_d     = 1'b0;
          credit_d = '0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      price_q  <= '0;
      tid_q    <= '0;
      tv_q     <= 1'b0;
      cv_q     <= 1'b0;
      camt_q   <= '0;
      rej_q    <= 1'b0;
      serr_q   <= 1'b0;
      busy_q   <= 1'b0;
      sold_q   <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      price_q  <= price_d;
      tid_q    <= tid_d;
      tv_q     <= tv_d;
      cv_q     <= cv_d;
      camt_q   <= camt_d;
      rej_q    <= rej_d;
      serr_q   <= serr_d;
      busy_q   <= busy_d;
      sold_q   <= sold_d;
    end
  end

  assign ticket_valid = tv_q;
  assign ticket_id    = tid_q;
  assign change_valid = cv_q;
  assign change_amt   = camt_q;
  assign credit       = credit_q;
  assign busy         = busy_q;
  assign coin_reject  = rej_q;
  assign sel_err      = serr_q;
  assign sold_cnt     = sold_q;
endmodule

// File: tb/tb_ptvm_multi_vend.sv
// Scoreboard bench for ptvm_multi_vend: expected tickets/change queued at stimulus, popped on handshakes.
module tb_ptvm_multi_vend;
  logic       clk = 1'b0;
  logic       rst, sel_valid, coin_valid, cancel, ticket_ready, change_ready;
  logic [2:0] sel_id;
  logic [1:0] coin_code;
  logic       ticket_valid, change_valid, busy, coin_reject, sel_err;
  logic [2:0] ticket_id;
  logic [7:0] change_amt, credit;
  logic [15:0] sold_cnt;

  int errs = 0, checks = 0;
  int tq[$];
  int cq[$];

  always #5 clk = ~clk;

  ptvm_multi_vend dut (
    .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel_id(sel_id),
    .coin_valid(coin_valid), .coin_code(coin_code), .cancel(cancel),
    .ticket_valid(ticket_valid), .ticket_id(ticket_id), .ticket_ready(ticket_ready),
    .change_valid(change_valid), .change_amt(change_amt), .change_ready(change_ready),
    .credit(credit), .busy(busy), .coin_reject(coin_reject), .sel_err(sel_err),
    .sold_cnt(sold_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sel(input logic [2:0] id);
    sel_valid = 1'b1; sel_id = id;
    cyc();
    sel_valid = 1'b0;
  endtask

  task automatic coin(input logic [1:0] code);
    coin_valid = 1'b1; coin_code = code;
    cyc();
    coin_valid = 1'b0;
  endtask

  // Handshakes sampled mid-cycle, before the edge that completes them.
  always @(negedge clk) begin
    if (!rst && ticket_valid && ticket_ready) begin
      if (tq.size() == 0) chk("ticket_unexpected", 1, 0);
      else chk("ticket_id", 32'(ticket_id), 32'(tq.pop_front()));
    end
    if (!rst && change_valid && change_ready) begin
      if (cq.size() == 0) chk("change_unexpected", 1, 0);
      else chk("change_amt", 32'(change_amt), 32'(cq.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sel_valid = 0; sel_id = 0; coin_valid = 0; coin_code = 0;
    cancel = 0; ticket_ready = 1'b1; change_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_credit", 32'(credit), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sold", 32'(sold_cnt), 0);
    chk("rst_tv", 32'(ticket_valid), 0);
    chk("rst_tid", 32'(ticket_id), 0);
    chk("rst_cv", 32'(change_valid), 0);
    chk("rst_camt", 32'(change_amt), 0);
    rst = 1'b0;
    cyc();

    // 1: exact payment, no change
    sel(3'd1);
    chk("t1_busy", 32'(busy), 1);
    coin(2'b10); chk("t1_cr2", 32'(credit), 2);
    coin(2'b10); chk("t1_cr4", 32'(credit), 4);
    tq.push_back(1);
    coin(2'b01);
    chk("t1_cr5", 32'(credit), 5);
    chk("t1_tv", 32'(ticket_valid), 1);
    cyc();
    chk("t1_tv_drop", 32'(ticket_valid), 0);
    chk("t1_cv", 32'(change_valid), 0);
    chk("t1_sold", 32'(sold_cnt), 1);
    chk("t1_credit0", 32'(credit), 0);
    chk("t1_idle", 32'(busy), 0);

    // 2: overpay, change of 2
    sel(3'd0);
    tq.push_back(0); cq.push_back(2);
    coin(2'b11);
    chk("t2_tv", 32'(ticket_valid), 1);
    cyc();
    chk("t2_cv", 32'(change_valid), 1);
    chk("t2_camt", 32'(change_amt), 2);
    cyc();
    chk("t2_credit0", 32'(credit), 0);
    chk("t2_idle", 32'(busy), 0);
    chk("t2_sold", 32'(sold_cnt), 2);

    // 3: cancel refunds; cancel beats a simultaneous coin
    for (int r = 0; r < 2; r++) begin
      sel(3'd3);
      coin(2'b11); coin(2'b11);
      chk("t3_cr10", 32'(credit), 10);
      cq.push_back(10);
      cancel = 1'b1;
      if (r == 1) begin coin_valid = 1'b1; coin_code = 2'b10; end
      cyc();
      cancel = 1'b0; coin_valid = 1'b0;
      if (r == 1) chk("t3_rej", 32'(coin_reject), 1);
      chk("t3_cv", 32'(change_valid), 1);
      chk("t3_camt", 32'(change_amt), 10);
      chk("t3_tv", 32'(ticket_valid), 0);
      cyc();
      chk("t3_credit0", 32'(credit), 0);
      chk("t3_sold", 32'(sold_cnt), 2);
    end

    // 4: printer stalls, coin in VEND rejected
    ticket_ready = 1'b0;
    sel(3'd1);
    coin(2'b11);
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        coin(2'b10);
        chk("t4_rej", 32'(coin_reject), 1);
      end else begin
        cyc();
        chk("t4_rej_clr", 32'(coin_reject), 0);
      end
      chk("t4_tv", 32'(ticket_valid), 1);
      chk("t4_tid", 32'(ticket_id), 1);
      chk("t4_credit", 32'(credit), 5);
    end
    tq.push_back(1);
    ticket_ready = 1'b1;
    cyc();
    chk("t4_tv_drop", 32'(ticket_valid), 0);
    chk("t4_sold", 32'(sold_cnt), 3);

    // 5: bad selection, ignored reselection, invalid coin
    sel(3'd6);
    chk("t5_serr", 32'(sel_err), 1);
    chk("t5_idle", 32'(busy), 0);
    cyc();
    chk("t5_serr_clr", 32'(sel_err), 0);
    sel(3'd1);
    sel(3'd2);
    chk("t5_noserr", 32'(sel_err), 0);
    coin(2'b00);
    chk("t5_rej00", 32'(coin_reject), 1);
    chk("t5_cr0", 32'(credit), 0);
    tq.push_back(1);
    coin(2'b11);
    chk("t5_tv", 32'(ticket_valid), 1);
    chk("t5_tid", 32'(ticket_id), 1);
    cyc();
    chk("t5_sold", 32'(sold_cnt), 4);

    // 6: reset mid-collection discards credit
    sel(3'd3);
    coin(2'b11); coin(2'b10);
    chk("t6_cr7", 32'(credit), 7);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_credit", 32'(credit), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_cv", 32'(change_valid), 0);
    chk("t6_sold", 32'(sold_cnt), 0);
    repeat (2) cyc();

    chk("tq_empty", 32'(tq.size()), 0);
    chk("cq_empty", 32'(cq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
